// File: rtl/vga_vram_scanner.sv
// 640x480@60Hz raster scanner for a 128x96 1-bit RGB frame buffer, each stored pixel upscaled to SCALE x SCALE.
// Optional macro BORDER_EN forces a white one-pixel frame around the visible area.
module vga_vram_scanner #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SCALE     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        red_in,
    input  logic        green_in,
    input  logic        blue_in,
    output logic [13:0] address,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int TW = $clog2(CLK_DIV);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int SW = $clog2(SCALE + 1);
    localparam logic [6:0] COL_MAX = 7'd127;
    localparam logic [6:0] ROW_MAX = 7'd95;

    logic [TW-1:0] tick_p0;
    logic [HW-1:0] hcount_p0;
    logic [VW-1:0] vcount_p0;
    logic [SW-1:0] hsub_p0;
    logic [SW-1:0] vsub_p0;
    logic [6:0]    col_p0;
    logic [6:0]    row_p0;
    logic          pix_tick;
    logic          h_wrap;
    logic          v_wrap;
    logic          hsub_wrap;
    logic          vsub_wrap;
    logic          visible;
    logic          hs_on;
    logic          vs_on;
    logic          force_on;

    function automatic logic [6:0] sat_inc(input logic [6:0] v, input logic [6:0] lim);
        return (v >= lim) ? lim : v + 7'd1;
    endfunction

    function automatic logic [3:0] dac(input logic d, input logic vis, input logic frc);
        return vis ? (frc ? 4'hF : {4{d}}) : 4'h0;
    endfunction

    assign pix_tick  = (tick_p0 == TW'(CLK_DIV - 1));
    assign h_wrap    = (hcount_p0 == HW'(H_TOTAL - 1));
    assign v_wrap    = (vcount_p0 == VW'(V_TOTAL - 1));
    assign hsub_wrap = (hsub_p0 == SW'(SCALE - 1));
    assign vsub_wrap = (vsub_p0 == SW'(SCALE - 1));
    assign visible   = (hcount_p0 < HW'(H_VISIBLE)) && (vcount_p0 < VW'(V_VISIBLE));
    assign hs_on     = (hcount_p0 >= HW'(H_VISIBLE + H_FP)) &&
                       (hcount_p0 <= HW'(H_VISIBLE + H_FP + H_SYNC - 1));
    assign vs_on     = (vcount_p0 >= VW'(V_VISIBLE + V_FP)) &&
                       (vcount_p0 <= VW'(V_VISIBLE + V_FP + V_SYNC - 1));

`ifdef BORDER_EN
    assign force_on = (hcount_p0 == '0) || (hcount_p0 == HW'(H_VISIBLE - 1)) ||
                      (vcount_p0 == '0) || (vcount_p0 == VW'(V_VISIBLE - 1));
`else
    assign force_on = 1'b0;
`endif

    // p0: pixel tick divider and raster counters; col/row stepped by sub-counters instead of dividers
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_p0   <= '0;
            hcount_p0 <= '0;
            vcount_p0 <= '0;
            hsub_p0   <= '0;
            vsub_p0   <= '0;
            col_p0    <= '0;
            row_p0    <= '0;
        end else begin
            tick_p0 <= pix_tick ? '0 : tick_p0 + TW'(1);
            if (pix_tick) begin
                if (h_wrap) begin
                    hcount_p0 <= '0;
                    hsub_p0   <= '0;
                    col_p0    <= '0;
                    if (v_wrap) begin
                        vcount_p0 <= '0;
                        vsub_p0   <= '0;
                        row_p0    <= '0;
                    end else begin
                        vcount_p0 <= vcount_p0 + VW'(1);
                        if (vsub_wrap) begin
                            vsub_p0 <= '0;
                            row_p0  <= sat_inc(row_p0, ROW_MAX);
                        end else begin
                            vsub_p0 <= vsub_p0 + SW'(1);
                        end
                    end
                end else begin
                    hcount_p0 <= hcount_p0 + HW'(1);
                    if (hsub_wrap) begin
                        hsub_p0 <= '0;
                        col_p0  <= sat_inc(col_p0, COL_MAX);
                    end else begin
                        hsub_p0 <= hsub_p0 + SW'(1);
                    end
                end
            end
        end
    end

    // p1: VRAM address, data returns one clock later, well before the next tick
    always_ff @(posedge clk) begin
        if (reset) begin
            address <= '0;
        end else begin
            address <= {row_p0, col_p0};
        end
    end

    // p2: sync and colour registered together on the tick, one pixel behind the counters
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            vga_red     <= 4'h0;
            vga_green   <= 4'h0;
            vga_blue    <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_tick && (hcount_p0 == '0) && (vcount_p0 == '0);
            if (pix_tick) begin
                hsync     <= ~hs_on;
                vsync     <= ~vs_on;
                vga_red   <= dac(red_in, visible, force_on);
                vga_green <= dac(green_in, visible, force_on);
                vga_blue  <= dac(blue_in, visible, force_on);
            end
        end
    end
endmodule

// File: tb/tb_vga_vram_scanner.sv
// Directed bench for vga_vram_scanner: full-size instance for line timing/addressing/reset,
// shrunk-raster instance for frame period and vsync timing.
module tb_vga_vram_scanner;
    logic        clk;
    logic        reset;
    logic        r, g, b;
    logic [13:0] address;
    logic [3:0]  vga_red, vga_green, vga_blue;
    logic        hsync, vsync, frame_start;
    logic        r_s, g_s, b_s;
    logic [13:0] address_s;
    logic [3:0]  red_s, green_s, blue_s;
    logic        hsync_s, vsync_s, frame_start_s;

    int cyc;
    int mode;
    int checks;
    int errors;

    vga_vram_scanner dut (
        .clk(clk), .reset(reset), .red_in(r), .green_in(g), .blue_in(b),
        .address(address), .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    vga_vram_scanner #(
        .CLK_DIV(2), .H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SCALE(2)
    ) dut_s (
        .clk(clk), .reset(reset), .red_in(r_s), .green_in(g_s), .blue_in(b_s),
        .address(address_s), .vga_red(red_s), .vga_green(green_s), .vga_blue(blue_s),
        .hsync(hsync_s), .vsync(vsync_s), .frame_start(frame_start_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // VRAM model, 1-clock read latency: 0 = all zero, 1 = all one, else address-derived bits
    always @(posedge clk) begin
        case (mode)
            0: begin r <= 1'b0; g <= 1'b0; b <= 1'b0; r_s <= 1'b0; g_s <= 1'b0; b_s <= 1'b0; end
            1: begin r <= 1'b1; g <= 1'b1; b <= 1'b1; r_s <= 1'b1; g_s <= 1'b1; b_s <= 1'b1; end
            default: begin
                r   <= address[0];
                g   <= address[7];
                b   <= address[0] ^ address[7];
                r_s <= address_s[0];
                g_s <= address_s[7];
                b_s <= address_s[0] ^ address_s[7];
            end
        endcase
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic goto(input int target);
        int n = 0;
        while (cyc != target && n < 100000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != target) chk("goto_timeout", cyc, target);
    endtask

    initial begin
        int fs_cnt = 0, fs_first = -1;
        int hs_low = 0, hs_fall1 = -1, hs_fall2 = -1;
        int vs_low = 0, f_cnt = 0, nz_cnt = 0;
        int fs_s1 = -1, fs_s2 = -1;
        int vs_s_low = 0, vs_s_first = -1, hs_s_low = 0, hs_s_first = -1, f_s_cnt = 0;
        logic hs_prev;
        int border_exp;

        checks = 0;
        errors = 0;
        mode   = 1;
        reset  = 1'b1;
        repeat (10) @(negedge clk);

        chk("rst_address", int'(address), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_red", int'(vga_red), 0);
        chk("rst_green", int'(vga_green), 0);
        chk("rst_blue", int'(vga_blue), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_s_hsync", int'(hsync_s), 1);
        chk("rst_s_vsync", int'(vsync_s), 1);

        reset   = 1'b0;
        hs_prev = hsync;
        // two full lines of the large raster, ~19 frames of the small one
        for (int c = 0; c <= 6403; c++) begin
            if (frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = cyc;
            end
            if (!hsync) hs_low++;
            if (hs_prev && !hsync) begin
                if (hs_fall1 < 0) hs_fall1 = cyc;
                else if (hs_fall2 < 0) hs_fall2 = cyc;
            end
            hs_prev = hsync;
            if (!vsync) vs_low++;
            if (vga_red == 4'hF && vga_green == 4'hF && vga_blue == 4'hF) f_cnt++;
            if (vga_red != 4'h0 || vga_green != 4'h0 || vga_blue != 4'h0) nz_cnt++;
            if (frame_start_s) begin
                if (fs_s1 < 0) fs_s1 = cyc;
                else if (fs_s2 < 0) fs_s2 = cyc;
            end
            if (cyc >= 2 && cyc <= 341) begin
                if (!vsync_s) begin
                    vs_s_low++;
                    if (vs_s_first < 0) vs_s_first = cyc;
                end
                if (!hsync_s) begin
                    hs_s_low++;
                    if (hs_s_first < 0) hs_s_first = cyc;
                end
                if (red_s == 4'hF && green_s == 4'hF && blue_s == 4'hF) f_s_cnt++;
            end
            @(negedge clk);
        end

        chk("frame_start_first", fs_first, 4);
        chk("frame_start_count", fs_cnt, 1);
        chk("hsync_low_clks", hs_low, 768);
        chk("hsync_fall_line0", hs_fall1, 2628);
        chk("hsync_fall_line1", hs_fall2, 5828);
        chk("vsync_low_lines01", vs_low, 0);
        chk("ones_white_clks", f_cnt, 5120);
        chk("ones_nonblank_clks", nz_cnt, 5120);
        chk("s_frame_start_first", fs_s1, 2);
        chk("s_frame_period", fs_s2, 342);
        chk("s_vsync_first_low", vs_s_first, 240);
        chk("s_vsync_low_clks", vs_s_low, 68);
        chk("s_hsync_first_low", hs_s_first, 26);
        chk("s_hsync_low_clks", hs_s_low, 60);
        chk("s_ones_white_clks", f_s_cnt, 120);

        // line 7: pixels 10..14 map to col 2, row 1
        mode = 2;
        goto(22440); chk("addr_x9_y7", int'(address), 'h81);
        goto(22441); chk("addr_x10_y7", int'(address), 'h82);
        goto(22452);
        chk("red_x12_y7", int'(vga_red), 0);
        chk("green_x12_y7", int'(vga_green), 15);
        chk("blue_x12_y7", int'(vga_blue), 15);
        chk("vsync_line7", int'(vsync), 1);
        goto(22455); chk("green_hold_x12_y7", int'(vga_green), 15);
        goto(22460); chk("addr_x14_y7", int'(address), 'h82);
        goto(22461); chk("addr_x15_y7", int'(address), 'h83);
        goto(22472);
        chk("red_x17_y7", int'(vga_red), 15);
        chk("green_x17_y7", int'(vga_green), 15);
        chk("blue_x17_y7", int'(vga_blue), 0);

        // one-clock reset in the middle of the line-8 hsync pulse
        goto(28300); chk("hsync_low_before_rst", int'(hsync), 0);
        mode  = 0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_hsync", int'(hsync), 1);
        chk("midrst_address", int'(address), 0);
        chk("midrst_red", int'(vga_red), 0);
        chk("midrst_frame_start", int'(frame_start), 0);
        reset = 1'b0;
        goto(3); chk("midrst_fs_cyc3", int'(frame_start), 0);
        goto(4); chk("midrst_fs_cyc4", int'(frame_start), 1);
        goto(5); chk("midrst_fs_cyc5", int'(frame_start), 0);
`ifdef BORDER_EN
        border_exp = 15;
`else
        border_exp = 0;
`endif
        goto(24);
        chk("addr_x5_y0", int'(address), 1);
        chk("red_x5_y0_zeros", int'(vga_red), border_exp);
        chk("blue_x5_y0_zeros", int'(vga_blue), border_exp);
        goto(3224); chk("red_x5_y1_zeros", int'(vga_red), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
